// File: rtl/mig_pkg.sv
// Shared types and helpers for the MIG truth-table sweeper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mig_pkg;

    // Node index width: constant 0, the primary inputs, then one node per gate.
    function automatic int idx_w(input int n_inputs, input int max_gates);
        return $clog2(1 + n_inputs + max_gates);
    endfunction

    typedef enum logic [1:0] {IDLE, EVAL, CAPT, DONE} state_t;

    // Operand/gate layouts at the default 7-input, 8-gate size; the top
    // declares the same layout at its own parameterised width.
    localparam int DEF_IDX_W = idx_w(7, 8);

    typedef struct packed {
        logic                 inv;
        logic [DEF_IDX_W-1:0] idx;
    } operand_t;

    typedef struct packed {
        operand_t c;
        operand_t b;
        operand_t a;
    } gate_cfg_t;

endpackage

// File: rtl/mig_tt_sweeper_if.sv
// Controller-side bundle of the MIG sweeper: config writes, sweep request, result.
// Latency: none (wires only).
// Backpressure: none; the controller watches busy/done, writes while busy are dropped.
interface mig_tt_sweeper_if #(
    parameter int N_INPUTS  = 7,
    parameter int MAX_GATES = 8,
    parameter int IDX_W     = mig_pkg::idx_w(N_INPUTS, MAX_GATES)
);
    import mig_pkg::*;

    logic                           cfg_we;
    logic [$clog2(MAX_GATES)-1:0]   cfg_addr;
    logic [3*(IDX_W+1)-1:0]         cfg_data;
    logic [$clog2(MAX_GATES+1)-1:0] num_gates;
    logic [IDX_W-1:0]               out_node;
    logic                           out_inv;
    logic                           start;
    logic                           busy;
    logic                           done;
    logic [2**N_INPUTS-1:0]         tt;

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_gates, out_node, out_inv, start,
        input  busy, done, tt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_gates, out_node, out_inv, start,
        output busy, done, tt
    );
endinterface

// File: rtl/mig_node_mux.sv
// Picks one node value (constant, primary input or gate register) and applies inversion.
// Latency: combinational.
// Backpressure: none; gates at or beyond limit_i read as 0 before inversion.
module mig_node_mux
    import mig_pkg::*;
#(
    parameter int N_INPUTS  = 7,
    parameter int MAX_GATES = 8,
    parameter int IDX_W     = idx_w(N_INPUTS, MAX_GATES),
    parameter int LIM_W     = $clog2(MAX_GATES + 1)
) (
    input  logic [IDX_W-1:0]     idx_i,
    input  logic                 inv_i,
    input  logic [N_INPUTS-1:0]  m_i,
    input  logic [MAX_GATES-1:0] gate_val_i,
    input  logic [LIM_W-1:0]     limit_i,
    output logic                 val_o
);
    logic sel;

    // Index 0 and any unmatched index fall through to the constant 0.
    always_comb begin
        sel = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_i == IDX_W'(i + 1)) sel = m_i[i];
        end
        for (int j = 0; j < MAX_GATES; j++) begin
            if ((idx_i == IDX_W'(N_INPUTS + 1 + j)) && (LIM_W'(j) < limit_i)) sel = gate_val_i[j];
        end
    end

    assign val_o = sel ^ inv_i;
endmodule

// File: rtl/mig_tt_sweeper.sv
// Enumerates all minterms of a loaded MIG and builds its truth table, one gate per clock.
// Latency: 2^N_INPUTS*(num_gates+1)+1 cycles from accepted start to the done pulse.
// Backpressure: start and cfg writes are dropped while a sweep is in progress.
module mig_tt_sweeper
    import mig_pkg::*;
#(
    parameter int N_INPUTS  = 7,
    parameter int MAX_GATES = 8,
    parameter int IDX_W     = idx_w(N_INPUTS, MAX_GATES)
) (
    input  logic            clk,
    input  logic            rst,
    mig_tt_sweeper_if.slave bus
);
    localparam int AW   = $clog2(MAX_GATES);
    localparam int GW   = $clog2(MAX_GATES + 1);
    localparam int TT_W = 2 ** N_INPUTS;

    typedef struct packed {
        logic             inv;
        logic [IDX_W-1:0] idx;
    } opnd_t;

    typedef struct packed {
        opnd_t c;
        opnd_t b;
        opnd_t a;
    } gcfg_t;

    gcfg_t                cfg_q [MAX_GATES];
    state_t               state_q;
    logic [N_INPUTS-1:0]  m_q;
    logic [GW-1:0]        g_q;
    logic [GW-1:0]        ng_q;
    logic [IDX_W-1:0]     out_node_q;
    logic                 out_inv_q;
    logic [MAX_GATES-1:0] gv_q;
    logic [TT_W-1:0]      tt_q;
    logic                 busy_q;
    logic                 done_q;

    gcfg_t cur_d;
    logic  va_d, vb_d, vc_d, gate_val_d, cap_d, cap_now_d;

    // Operands of the gate being evaluated this cycle.
    always_comb begin
        cur_d = '0;
        for (int j = 0; j < MAX_GATES; j++) begin
            if (g_q == GW'(j)) cur_d = cfg_q[j];
        end
    end

    // Operands may only see gates already evaluated for this minterm.
    mig_node_mux #(.N_INPUTS(N_INPUTS), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_a (
        .idx_i(cur_d.a.idx), .inv_i(cur_d.a.inv), .m_i(m_q), .gate_val_i(gv_q), .limit_i(g_q), .val_o(va_d));
    mig_node_mux #(.N_INPUTS(N_INPUTS), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_b (
        .idx_i(cur_d.b.idx), .inv_i(cur_d.b.inv), .m_i(m_q), .gate_val_i(gv_q), .limit_i(g_q), .val_o(vb_d));
    mig_node_mux #(.N_INPUTS(N_INPUTS), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_c (
        .idx_i(cur_d.c.idx), .inv_i(cur_d.c.inv), .m_i(m_q), .gate_val_i(gv_q), .limit_i(g_q), .val_o(vc_d));
    // The function output may see any active gate.
    mig_node_mux #(.N_INPUTS(N_INPUTS), .MAX_GATES(MAX_GATES), .IDX_W(IDX_W)) u_mux_out (
        .idx_i(out_node_q), .inv_i(out_inv_q), .m_i(m_q), .gate_val_i(gv_q), .limit_i(ng_q), .val_o(cap_d));

    assign gate_val_d = (va_d & vb_d) | (va_d & vc_d) | (vb_d & vc_d);
    // With zero gates the capture happens directly in EVAL, giving one cycle per minterm.
    assign cap_now_d  = (state_q == CAPT) || ((state_q == EVAL) && (g_q == ng_q));

    // Gate configuration store; frozen outside IDLE so a sweep sees a stable netlist.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < MAX_GATES; j++) cfg_q[j] <= '0;
        end else if (bus.cfg_we && (state_q == IDLE)) begin
            for (int j = 0; j < MAX_GATES; j++) begin
                if (bus.cfg_addr == AW'(j)) cfg_q[j] <= bus.cfg_data;
            end
        end
    end

    // Sweep sequencer: minterm/gate counters, gate-value registers, truth table and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= '0;
            g_q        <= '0;
            ng_q       <= '0;
            out_node_q <= '0;
            out_inv_q  <= 1'b0;
            gv_q       <= '0;
            tt_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.num_gates <= GW'(MAX_GATES))) begin
                        ng_q       <= bus.num_gates;
                        out_node_q <= bus.out_node;
                        out_inv_q  <= bus.out_inv;
                        tt_q       <= '0;
                        gv_q       <= '0;
                        m_q        <= '0;
                        g_q        <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= EVAL;
                    end
                end
                EVAL, CAPT: begin
                    if (cap_now_d) begin
                        tt_q[m_q] <= cap_d;
                        gv_q      <= '0;
                        g_q       <= '0;
                        if (m_q == '1) begin
                            state_q <= DONE;
                        end else begin
                            m_q     <= m_q + N_INPUTS'(1);
                            state_q <= EVAL;
                        end
                    end else begin
                        for (int j = 0; j < MAX_GATES; j++) begin
                            if (g_q == GW'(j)) gv_q[j] <= gate_val_d;
                        end
                        g_q <= g_q + GW'(1);
                        if ((g_q + GW'(1)) == ng_q) state_q <= CAPT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.tt   = tt_q;
endmodule

// File: tb/tb_mig_tt_sweeper.sv
// Self-checking bench for mig_tt_sweeper at N_INPUTS=7, MAX_GATES=8.
// Latency: checks the sweep length of every run against 128*(num_gates+1)+1.
// Backpressure: exercises dropped start/cfg writes mid-sweep and an aborting reset.
module tb_mig_tt_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mig_tt_sweeper_if #(.N_INPUTS(7), .MAX_GATES(8)) bus ();

    mig_tt_sweeper #(.N_INPUTS(7), .MAX_GATES(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0][14:0] cfg;
        logic [3:0]       ng;
        logic [3:0]       on;
        logic             oi;
        logic [127:0]     tt;
        logic [31:0]      lat;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [4:0] op(input logic inv, input int idx);
        return {inv, 4'(idx)};
    endfunction

    function automatic logic [14:0] gt(input logic [4:0] c, input logic [4:0] b, input logic [4:0] a);
        return {c, b, a};
    endfunction

    // Reference: evaluate every minterm straight from the node-space rules.
    function automatic logic [127:0] model_tt(input logic [7:0][14:0] cfg, input int ng, input int on, input bit oi);
        logic [127:0] r;
        int           node [16];
        logic [14:0]  gw;
        logic [4:0]   o;
        int           idx, ones, v;
        r = '0;
        for (int m = 0; m < 128; m++) begin
            for (int i = 0; i < 16; i++) node[i] = 0;
            for (int i = 0; i < 7; i++) node[i+1] = (m >> i) & 1;
            for (int g = 0; g < ng; g++) begin
                gw   = cfg[g];
                ones = 0;
                for (int k = 0; k < 3; k++) begin
                    o    = gw[k*5 +: 5];
                    idx  = int'(o[3:0]);
                    v    = (idx <= 7 || (idx - 8) < g) ? node[idx] : 0;
                    ones = ones + (v ^ int'(o[4]));
                end
                node[8+g] = (ones >= 2) ? 1 : 0;
            end
            v    = (on <= 7 || (on - 8) < ng) ? node[on] : 0;
            r[m] = 1'(v) ^ oi;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int addr, input logic [14:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(addr);
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0][14:0] cfg);
        for (int j = 0; j < 8; j++) write_cfg(j, cfg[j]);
    endtask

    // Start a sweep and wait (bounded) for done; returns tt and cycles from the start edge.
    task automatic run_sweep(input string name, input int ng, input int on, input bit oi,
                             input bit same_we, input int we_addr, input logic [14:0] we_data,
                             input bit disturb, output logic [127:0] tt_got, output int lat);
        bit seen;
        bus.num_gates = 4'(ng);
        bus.out_node  = 4'(on);
        bus.out_inv   = oi;
        bus.start     = 1'b1;
        if (same_we) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 3'(we_addr);
            bus.cfg_data = we_data;
        end
        tick();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        seen   = 1'b0;
        lat    = 0;
        tt_got = '0;
        for (int c = 1; c <= 2000 && !seen; c++) begin
            if (disturb && c == 100) begin
                bus.start    = 1'b1;
                bus.num_gates = 4'd0;
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 3'd0;
                bus.cfg_data = 15'h7fff;
            end
            tick();
            if (disturb && c == 100) begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (c == 1) chk({name, " busy_after_start"}, 128'(bus.busy), 128'd1);
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: no done within 2000 cycles, expected one", name);
        end else begin
            tt_got = bus.tt;
            chk({name, " busy_at_done"}, 128'(bus.busy), 128'd0);
            tick();
            chk({name, " done_one_cycle"}, 128'(bus.done), 128'd0);
        end
    endtask

    task automatic add_vec(input logic [7:0][14:0] cfg, input int ng, input int on, input bit oi,
                           input logic [127:0] tt, input int lat);
        vec_t v;
        v.cfg = cfg;
        v.ng  = 4'(ng);
        v.on  = 4'(on);
        v.oi  = oi;
        v.tt  = tt;
        v.lat = 32'(lat);
        tbl.push_back(v);
    endtask

    logic [7:0][14:0] c_maj, c_and, c_fwd, c_fwdi, c_self, c_chain, c_rnd;
    logic [127:0]     golden, tt_got, exp_tt;
    int               lat, ng, on;
    bit               oi, done_seen;

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.num_gates = '0;
        bus.out_node  = '0;
        bus.out_inv   = 1'b0;
        bus.start     = 1'b0;

        golden = 128'hfeeaeae8eaeaea88eea8a8a8e8a8a880;
        c_maj   = '0; c_maj[0]  = gt(op(0, 3), op(0, 2), op(0, 1));
        c_and   = '0; c_and[0]  = gt(op(0, 2), op(0, 1), op(0, 0));
        c_fwd   = '0; c_fwd[0]  = gt(op(0, 9), op(0, 2), op(0, 1));
        c_fwdi  = '0; c_fwdi[0] = gt(op(1, 9), op(0, 2), op(0, 1));
        c_self  = '0; c_self[0] = gt(op(0, 8), op(0, 2), op(0, 1));
        c_chain = '0;
        c_chain[0] = gt(op(0, 5),  op(0, 4),  op(0, 3));
        c_chain[1] = gt(op(0, 5),  op(0, 4),  op(0, 1));
        c_chain[2] = gt(op(0, 8),  op(0, 2),  op(0, 1));
        c_chain[3] = gt(op(0, 9),  op(0, 7),  op(0, 2));
        c_chain[4] = gt(op(0, 10), op(0, 6),  op(0, 3));
        c_chain[5] = gt(op(0, 12), op(0, 11), op(0, 1));

        add_vec(c_maj,   1, 8,  0, {16{8'hE8}}, 257);
        add_vec(c_and,   1, 8,  0, {32{4'h8}},  257);
        add_vec(c_and,   1, 8,  1, {32{4'h7}},  257);
        add_vec(c_maj,   0, 1,  0, {16{8'hAA}}, 129);
        add_vec(c_maj,   0, 7,  0, {{64{1'b1}}, {64{1'b0}}}, 129);
        add_vec(c_fwd,   1, 8,  0, {32{4'h8}},  257);
        add_vec(c_fwdi,  1, 8,  0, {32{4'hE}},  257);
        add_vec(c_self,  1, 8,  0, {32{4'h8}},  257);
        add_vec(c_maj,   1, 10, 1, {128{1'b1}}, 257);
        add_vec(c_chain, 6, 13, 0, golden,      897);

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset done", 128'(bus.done), 128'd0);
        chk("reset tt",   bus.tt,         128'd0);

        // Directed table
        foreach (tbl[i]) begin
            load_cfg(tbl[i].cfg);
            run_sweep($sformatf("vec%0d", i), int'(tbl[i].ng), int'(tbl[i].on), tbl[i].oi,
                      1'b0, 0, '0, 1'b0, tt_got, lat);
            chk($sformatf("vec%0d tt", i),  tt_got,      tbl[i].tt);
            chk($sformatf("vec%0d lat", i), 128'(lat),   128'(tbl[i].lat));
        end

        // Config write in the same cycle as start lands before the sweep reads it
        write_cfg(5, '0);
        run_sweep("same_cycle_we", 6, 13, 0, 1'b1, 5, c_chain[5], 1'b0, tt_got, lat);
        chk("same_cycle_we tt",  tt_got,    golden);
        chk("same_cycle_we lat", 128'(lat), 128'd897);

        // start and cfg_we pulsed mid-sweep are dropped
        run_sweep("disturbed", 6, 13, 0, 1'b0, 0, '0, 1'b1, tt_got, lat);
        chk("disturbed tt",  tt_got,    golden);
        chk("disturbed lat", 128'(lat), 128'd897);

        // Oversized num_gates is refused; tt holds the previous result
        bus.num_gates = 4'd9;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("ng9 ignored busy", 128'(bus.busy), 128'd0);
        chk("tt held after done", bus.tt, golden);

        // Reset in the middle of a sweep
        bus.num_gates = 4'd6;
        bus.out_node  = 4'd13;
        bus.out_inv   = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (299) tick();
        chk("mid-sweep busy", 128'(bus.busy), 128'd1);
        #3 rst = 1'b1;
        #1;
        chk("abort busy", 128'(bus.busy), 128'd0);
        chk("abort tt",   bus.tt,         128'd0);
        tick();
        rst = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (bus.done) done_seen = 1'b1;
        end
        chk("abort no done", 128'(done_seen), 128'd0);
        // Configuration came back as all-zero operands: gate0 = MAJ(0,0,0)
        run_sweep("cfg_cleared", 1, 8, 1, 1'b0, 0, '0, 1'b0, tt_got, lat);
        chk("cfg_cleared tt", tt_got, {128{1'b1}});
        load_cfg(c_chain);
        run_sweep("after_abort", 6, 13, 0, 1'b0, 0, '0, 1'b0, tt_got, lat);
        chk("after_abort tt",  tt_got,    golden);
        chk("after_abort lat", 128'(lat), 128'd897);

        // Random netlists against the reference model
        for (int it = 0; it < 15; it++) begin
            for (int j = 0; j < 8; j++) begin
                c_rnd[j] = gt(op(1'($urandom_range(0, 1)), $urandom_range(0, 15)),
                              op(1'($urandom_range(0, 1)), $urandom_range(0, 15)),
                              op(1'($urandom_range(0, 1)), $urandom_range(0, 15)));
            end
            ng = $urandom_range(0, 8);
            if (ng > 0 && $urandom_range(0, 1) == 1) on = 7 + ng;
            else on = $urandom_range(0, 15);
            oi = 1'($urandom_range(0, 1));
            exp_tt = model_tt(c_rnd, ng, on, oi);
            load_cfg(c_rnd);
            run_sweep($sformatf("rnd%0d", it), ng, on, oi, 1'b0, 0, '0, 1'b0, tt_got, lat);
            chk($sformatf("rnd%0d tt ng=%0d on=%0d", it, ng, on), tt_got, exp_tt);
            chk($sformatf("rnd%0d lat", it), 128'(lat), 128'(128 * (ng + 1) + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mig_tt_sweeper.md
# mig_tt_sweeper

Programmable majority-inverter-graph (MIG) evaluator that enumerates all 2^N_INPUTS input assignments and assembles the complete truth table of the configured network. It is the parametrised, run-time-loadable successor to our fixed 7-input majority netlists. It sits between the classification controller, which loads gate lists and reads back truth tables, and the canonicalisation stage. One majority gate is evaluated per clock cycle.

## Interface
Parameters:
- N_INPUTS, 7, number of primary inputs x0..x(N_INPUTS-1); legal range 2..8.
- MAX_GATES, 8, depth of the gate configuration store.
- IDX_W, $clog2(1+N_INPUTS+MAX_GATES), node index width (derived).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cfg_we  in  1  write strobe for one gate entry; ignored while busy.
- cfg_addr  in  $clog2(MAX_GATES)  gate slot to write.
- cfg_data  in  3*(IDX_W+1)  operands {c,b,a}. Each operand is {inv, idx}; operand a occupies the LSBs.
- num_gates  in  $clog2(MAX_GATES+1)  number of active gates; sampled on start.
- out_node  in  IDX_W  node driving the function output; sampled on start.
- out_inv  in  1  complements the function output; sampled on start.
- start  in  1  one-cycle request to begin a sweep.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when tt is valid.
- tt  out  2^N_INPUTS  truth table. Bit m = f(x = m), with x0 = LSB of m.

## Operation
- Node space: index 0 = constant 0; 1..N_INPUTS = x0..x(N_INPUTS-1); N_INPUTS+1+g = output of gate g.
- Gate g value = MAJ(a', b', c'), where each operand is node[idx] XOR inv.
- States:
  - IDLE: start accepted, or ignored if num_gates > MAX_GATES. Latches num_gates/out_node/out_inv, clears tt and the gate-value registers, sets m=0, g=0. Goes to EVAL.
  - EVAL: evaluates gate g for minterm m and writes its value register; g++. When g == num_gates, goes to CAPT.
  - CAPT: tt[m] = node[out_node] XOR out_inv. Then either clears gate-value registers, m++, g=0 and returns to EVAL, or, if m == 2^N_INPUTS-1, goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- With num_gates=0, EVAL falls straight through to CAPT in the same cycle. Each minterm then takes one cycle, which allows pure input/constant outputs.
- Gate-value registers are cleared per minterm. An operand referencing gate ≥ current g, or an index beyond the active range, reads 0 (before inv).
- tt holds its value after done until the next accepted start or reset.
- start while busy is ignored. cfg_we while busy is ignored; the configuration store is stable during a sweep.
- Configuration store contents survive sweeps. Reset clears them to all-zero operands.

## Timing
- Reset values: busy=0, done=0, tt=0, state=IDLE, m=0, g=0, config store all zero.
- Sweep latency from the start edge to the done pulse is 2^N_INPUTS*(num_gates+1)+1 cycles.
  - Example: N_INPUTS=7, num_gates=6 gives 897 cycles.
- busy deasserts in the same cycle done pulses.
- A cfg write and a start in the same cycle while IDLE: the write lands first, and the sweep uses the new entry.
- Reset asserted mid-sweep aborts immediately: busy=0, done never pulses, tt=0.
- m wraps only through CAPT→DONE and never re-enters EVAL.

## Structure
- Package mig_pkg:
  - operand typedef {inv, idx}.
  - gate_cfg_t of three operands.
  - state enum {IDLE, EVAL, CAPT, DONE}.
  - IDX_W derivation function.
- Sub-module mig_node_mux: selects node[idx] from constant/inputs/gate registers and applies inv. Instantiated three times for the operands, plus once for out_node.
- Top holds the FSM, the m/g counters, the configuration store and the tt register.

## Test plan
- Single gate {x2,x1,x0}, num_gates=1, out_node=8 -> tt = 0xE8 repeated 16×, done at cycle 257.
- AND via constant: gate {x1,x0,const0}, out_node=8 -> tt = 0x8 repeated 32×. Same config with out_inv=1 -> 0x7 repeated 32×.
- Six-gate chain:
  - Gates: g0=M(x2,x3,x4), g1=M(x0,x3,x4), g2=M(x0,x1,g0), g3=M(x1,x6,g1), g4=M(x2,x5,g2), g5=M(x0,g3,g4).
  - Configuration: out_node=13, num_gates=6.
  - Required response: tt = 128'hfeeaeae8eaeaea88eea8a8a8e8a8a880, done exactly 897 cycles after start.
- num_gates=0, out_node=1 (x0) -> tt = 0xAA repeated 16×, done at cycle 129. A forward-referencing gate operand reads 0.
- start and cfg_we pulsed mid-sweep -> both ignored, tt identical to the undisturbed run.
- rst pulsed at cycle 300 of a sweep -> busy=0 and tt=0 asynchronously, no done. A fresh start afterwards reproduces the golden tt.
